// File: rtl/rstn_gen.sv
// rstn_gen: active-low reset conditioner / debouncer. Assertion is immediate and asynchronous,
// release waits for TICK clean clk edges. Define RSTN_GEN_SYNC_EN to add a 2-flop release synchronizer.
module rstn_gen #(
  parameter int unsigned TICK = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_rstn,
  output logic o_rstn
);

  // widened so that TICK = 2^32-1 does not wrap when sizing the counter
  localparam int unsigned CW = $clog2(64'(TICK) + 64'd1);
  localparam logic [CW-1:0] TICK_C = CW'(TICK);

  if (TICK < 32'd1) begin : g_tick_check
    $error("rstn_gen: TICK must be at least 1");
  end

  logic          clr_n;
  logic          cnt_en;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  assign clr_n = rstn & i_rstn;

`ifdef RSTN_GEN_SYNC_EN
  logic [1:0] sync_q;

  // ones ripple in only after clr_n has been high for two edges
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign cnt_en = sync_q[1];
`else
  assign cnt_en = 1'b1;
`endif

  // saturating count so a released output can never re-assert on its own
  always_comb begin
    cnt_next = cnt;
    if (cnt_en && (cnt < TICK_C)) begin
      cnt_next = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt    <= '0;
      o_rstn <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      o_rstn <= (cnt_next == TICK_C);
    end
  end

endmodule

// File: tb/tb_rstn_gen.sv
// tb_rstn_gen: three rstn_gen instances (TICK = 1, 3, 4) driven in parallel and compared
// against an edge-counting reference model; directed bounce/glitch cases followed by random traffic.
`timescale 1ns/1ps
module tb_rstn_gen;

`ifdef RSTN_GEN_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic clk;
  logic rstn;
  logic i_rstn;
  logic o_rstn_t1;
  logic o_rstn_t3;
  logic o_rstn_t4;
  logic clr_tb;

  int checks = 0;
  int failures = 0;
  int clean_edges = 0;

  rstn_gen #(.TICK(1)) dut_t1 (.clk(clk), .rstn(rstn), .i_rstn(i_rstn), .o_rstn(o_rstn_t1));
  rstn_gen #(.TICK(3)) dut_t3 (.clk(clk), .rstn(rstn), .i_rstn(i_rstn), .o_rstn(o_rstn_t3));
  rstn_gen #(.TICK(4)) dut_t4 (.clk(clk), .rstn(rstn), .i_rstn(i_rstn), .o_rstn(o_rstn_t4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign clr_tb = rstn & i_rstn;

  // reference: number of rising edges seen since both inputs were last high together
  always @(posedge clk or negedge clr_tb) begin
    if (!clr_tb) begin
      clean_edges = 0;
    end else if (clean_edges < 1000) begin
      clean_edges = clean_edges + 1;
    end
  end

  function automatic logic expectedOut(input int tick);
    return clr_tb && (clean_edges >= tick + EXTRA);
  endfunction

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks = checks + 1;
    if (observed !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s at %0t: got o_rstn=%b expected %b (edges since release=%0d)",
               tag, $time, observed, expected, clean_edges);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_tick1"}, o_rstn_t1, expectedOut(1));
    checkOutput({tag, "_tick3"}, o_rstn_t3, expectedOut(3));
    checkOutput({tag, "_tick4"}, o_rstn_t4, expectedOut(4));
  endtask

  // advance n cycles, sampling 1 ns after each falling edge, well away from the active edge
  task automatic stepCycles(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      checkAll(tag);
    end
  endtask

  // mid-cycle input change followed by an immediate check of the asynchronous path
  task automatic applyStimulus(input string tag, input logic new_rstn, input logic new_i_rstn);
    #1;
    rstn   = new_rstn;
    i_rstn = new_i_rstn;
    #1;
    checkAll(tag);
  endtask

  // 1 ns low pulse on i_rstn placed between clock edges
  task automatic glitch(input string tag);
    #1;
    i_rstn = 1'b0;
    #1;
    checkAll(tag);
    i_rstn = 1'b1;
  endtask

  initial begin
    rstn   = 1'b0;
    i_rstn = 1'b0;
    stepCycles("reset", 3);

    applyStimulus("rstn_up", 1'b1, 1'b0);
    stepCycles("key_low", 5);
    applyStimulus("key_up", 1'b1, 1'b1);
    stepCycles("release", 25);

    applyStimulus("bounce_drop", 1'b1, 1'b0);
    stepCycles("bounce_low", 2);
    applyStimulus("bounce_rise", 1'b1, 1'b1);
    stepCycles("bounce_count", 2);
    glitch("bounce_glitch");
    stepCycles("bounce_recount", 7);

    glitch("post_release_glitch");
    stepCycles("post_release_recount", 8);

    applyStimulus("rstn_drop", 1'b0, 1'b1);
    stepCycles("rstn_held", 3);
    applyStimulus("rstn_rise", 1'b1, 1'b1);
    stepCycles("rstn_release", 8);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    applyStimulus("rand_key", 1'b1, 1'($urandom_range(0, 1)));
        2:       applyStimulus("rand_rstn", 1'($urandom_range(0, 1)), i_rstn);
        3:       if (clr_tb) glitch("rand_glitch");
        default: applyStimulus("rand_hold", 1'b1, i_rstn);
      endcase
      stepCycles("rand", 1);
    end

    applyStimulus("final_up", 1'b1, 1'b1);
    stepCycles("final_release", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
